// File: rtl/aes_mixcol_sched_if.sv
// Handshake bundle for the AES (Inv)MixColumns scheduler: input state, result and status.
// No latency: wires only.
// Backpressure is carried by in_ready (block to producer) and out_ready (consumer to block).
interface aes_mixcol_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_mixcol_sched.sv
// AES MixColumns / InvMixColumns over a 128-bit state; byte-serial by default, column-parallel with MIXCOL_PARALLEL_EN.
// Latency: out_valid 17 cycles after the accept edge (5 with MIXCOL_PARALLEL_EN); one state in flight.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, with no same-cycle turnaround.
module aes_mixcol_sched (
    input  logic               clk,
    input  logic               rst_n,
    aes_mixcol_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef MIXCOL_PARALLEL_EN
    localparam logic [3:0] LAST_K = 4'd3;
`else
    localparam logic [3:0] LAST_K = 4'd15;
`endif

    state_t          state;
    logic [3:0]      k;
    logic            mode;
    logic [15:0][7:0] src;
    logic [15:0][7:0] res;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_data  = res;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the state lives at packed index 15-k (byte 0 is the MSB).
    function automatic logic [7:0] sel(input logic [15:0][7:0] s, input logic [3:0] i);
        return s[4'd15 - i];
    endfunction

    function automatic logic [7:0] mix(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d,
                                       input logic inv);
        logic [7:0] a2, a4, a8, b2, b4, b8, c2, c4, c8, d2, d4, d8;
        a2 = xt(a); a4 = xt(a2); a8 = xt(a4);
        b2 = xt(b); b4 = xt(b2); b8 = xt(b4);
        c2 = xt(c); c4 = xt(c2); c8 = xt(c4);
        d2 = xt(d); d4 = xt(d2); d8 = xt(d4);
        if (inv)
            return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
        else
            return a2 ^ (b2 ^ b) ^ c ^ d;
    endfunction

`ifdef MIXCOL_PARALLEL_EN
    logic [1:0]      col;
    logic [3:0][7:0] col_out;

    assign col = k[1:0];

    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            col_out[r] = mix(sel(src, {col, 2'(r)}),
                             sel(src, {col, 2'(r) + 2'd1}),
                             sel(src, {col, 2'(r) + 2'd2}),
                             sel(src, {col, 2'(r) + 2'd3}),
                             mode);
        end
    end
`else
    logic [1:0] col;
    logic [1:0] row;
    logic [7:0] mix_out;

    assign col = k[3:2];
    assign row = k[1:0];

    always_comb begin
        mix_out = mix(sel(src, {col, row}),
                      sel(src, {col, row + 2'd1}),
                      sel(src, {col, row + 2'd2}),
                      sel(src, {col, row + 2'd3}),
                      mode);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            mode        <= 1'b0;
            src         <= '0;
            res         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        src        <= bus.in_data;
                        mode       <= bus.in_inv;
                        k          <= '0;
                        state      <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
`ifdef MIXCOL_PARALLEL_EN
                    for (int r = 0; r < 4; r++)
                        res[4'd15 - {col, 2'(r)}] <= col_out[r];
`else
                    res[4'd15 - k] <= mix_out;
`endif
                    if (k == LAST_K) begin
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle only raises out_valid so the result is presented from a settled register.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule
